// File: rtl/serial_adder_fsm.sv
// Bit-serial adder/subtractor: captures two operands, resolves one bit per clock LSB-first
// through a single full-adder slice, and presents serial and parallel results.
module serial_adder_fsm #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             NRST,
   input  logic             start,
   input  logic             rst,
   input  logic             MODE,
   input  logic             CIN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             SBIT,
   output logic             SBIT_VLD,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;

   logic             sum;
   logic             carry_nxt;
   logic             last_bit;
   logic [WIDTH-1:0] s_nxt;

   // Full-adder slice on the current LSBs; the sum enters the result from the MSB end.
   always_comb begin
      sum       = a_q[0] ^ b_q[0] ^ carry_q;
      carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
      s_nxt     = (S >> 1) | (WIDTH'(sum) << (WIDTH - 1));
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         SBIT     <= 1'b0;
         SBIT_VLD <= 1'b0;
         S        <= '0;
         COUT     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= 1'b0;
         SBIT_VLD <= 1'b0;
         if (rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            SBIT    <= 1'b0;
            S       <= '0;
            COUT    <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     // Subtraction is A + ~B + ~borrow, so the slice itself is add-only.
                     a_q     <= A;
                     b_q     <= MODE ? ~B : B;
                     carry_q <= MODE ? ~CIN : CIN;
                     cnt_q   <= '0;
                     S       <= '0;
                     busy    <= 1'b1;
                     state_q <= StRun;
                  end
               end
               StRun: begin
                  a_q      <= a_q >> 1;
                  b_q      <= b_q >> 1;
                  carry_q  <= carry_nxt;
                  cnt_q    <= cnt_q + CNT_W'(1);
                  S        <= s_nxt;
                  SBIT     <= sum;
                  SBIT_VLD <= 1'b1;
                  if (last_bit) begin
                     COUT    <= carry_nxt;
                     done    <= 1'b1;
                     state_q <= StDone;
                  end
               end
               StDone: begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
               default: begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule
